// File: rtl/riscv_pkg.sv
// Shared RV32 encodings and types used by the execute-stage datapath.
package riscv_pkg;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_e;

    typedef struct packed {
        logic valid;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic branch_taken;
    } ex_mem_ctl_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: operands captured once as magnitudes,
// one partial product per cycle, sign fixed up on the way out.
module mul_iter
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            a_signed_i,
    input  logic            b_signed_i,
    input  logic            hi_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);

    mul_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d, prod;
    logic [XLEN-1:0]   mplier_q, mplier_d, a_mag, b_mag;
    logic              neg_q, neg_d, hi_q, hi_d, a_neg, b_neg;

    assign a_neg = a_signed_i & op_a_i[XLEN-1];
    assign b_neg = b_signed_i & op_b_i[XLEN-1];
    assign a_mag = a_neg ? -op_a_i : op_a_i;
    assign b_mag = b_neg ? -op_b_i : op_b_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            hi_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MUL_IDLE: if (start_i) state_d = MUL_RUN;
            MUL_RUN: begin
                if (abort_i)
                    state_d = MUL_IDLE;
                else if (cnt_q == CW'(XLEN - 1))
                    state_d = MUL_DONE;
            end
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        if (state_q == MUL_IDLE && start_i) begin
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{XLEN{1'b0}}, a_mag};
            mplier_d = b_mag;
            neg_d    = a_neg ^ b_neg;
            hi_d     = hi_i;
        end else if (state_q == MUL_RUN) begin
            if (mplier_q[0])
                acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    assign busy_o   = (state_q == MUL_IDLE && start_i) || state_q == MUL_RUN;
    assign done_o   = state_q == MUL_DONE;
    assign prod     = neg_q ? -acc_q : acc_q;
    assign result_o = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, branch resolve, iterative multiply and
// the EX/MEM pipeline register.
module ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_ex_valid,
    input  logic [XLEN-1:0] id_ex_pc,
    input  logic [XLEN-1:0] id_ex_rs1val,
    input  logic [XLEN-1:0] id_ex_rs2val,
    input  logic [XLEN-1:0] id_ex_immediate,
    input  logic [4:0]      id_ex_rs1,
    input  logic [4:0]      id_ex_rs2,
    input  logic [4:0]      id_ex_rd,
    input  logic [2:0]      id_ex_funct3,
    input  logic [6:0]      id_ex_funct7,
    input  logic            id_ex_ALUSrc,
    input  logic            id_ex_MemtoReg,
    input  logic            id_ex_MemRead,
    input  logic            id_ex_MemWrite,
    input  logic            id_ex_Branch,
    input  logic            id_ex_RegWrite,
    input  logic [1:0]      id_ex_ALUOp,
    input  logic            mem_wb_RegWrite,
    input  logic [4:0]      mem_wb_rd,
    input  logic [XLEN-1:0] Write_data,
    input  logic            flush,
    output logic            ex_busy,
    output logic            ex_mem_valid,
    output logic            ex_mem_MemtoReg,
    output logic            ex_mem_MemRead,
    output logic            ex_mem_MemWrite,
    output logic            ex_mem_RegWrite,
    output logic            ex_mem_branch_taken,
    output logic [XLEN-1:0] ex_mem_branch_target,
    output logic [XLEN-1:0] ex_mem_alu_result,
    output logic [XLEN-1:0] ex_mem_store_data,
    output logic [4:0]      ex_mem_rd
);
    localparam int SW = $clog2(XLEN);

    ex_mem_ctl_t     ctl_q, ctl_d;
    logic [XLEN-1:0] tgt_q, res_q, sd_q;
    logic [4:0]      rd_q;

    logic [XLEN-1:0] op_a, fwd_b, op_b, alu_y, mul_y, result;
    logic [SW-1:0]   shamt;
    logic            ex_ok, wb_ok, br_cond;
    logic            mul_start, mul_done;
    alu_op_e         alu_op;

    // Loads are excluded: their EX/MEM result is an address, not data.
    assign ex_ok = ctl_q.reg_write && !ctl_q.mem_read && rd_q != 5'd0;
    assign wb_ok = mem_wb_RegWrite && mem_wb_rd != 5'd0;

    assign op_a  = (ex_ok && rd_q == id_ex_rs1) ? res_q :
                   (wb_ok && mem_wb_rd == id_ex_rs1) ? Write_data : id_ex_rs1val;
    assign fwd_b = (ex_ok && rd_q == id_ex_rs2) ? res_q :
                   (wb_ok && mem_wb_rd == id_ex_rs2) ? Write_data : id_ex_rs2val;
    assign op_b  = id_ex_ALUSrc ? id_ex_immediate : fwd_b;
    assign shamt = op_b[SW-1:0];

    always_comb begin
        alu_op = ALU_ADD;
        unique case (id_ex_ALUOp)
            ALUOP_ADD: alu_op = ALU_ADD;
            ALUOP_BR:  alu_op = ALU_SUB;
            ALUOP_R, ALUOP_I: begin
                unique case (id_ex_funct3)
                    F3_ADD:  alu_op = (id_ex_ALUOp == ALUOP_R && id_ex_funct7[5])
                                      ? ALU_SUB : ALU_ADD;
                    F3_SLL:  alu_op = ALU_SLL;
                    F3_SLT:  alu_op = ALU_SLT;
                    F3_SLTU: alu_op = ALU_SLTU;
                    F3_XOR:  alu_op = ALU_XOR;
                    F3_SR:   alu_op = id_ex_funct7[5] ? ALU_SRA : ALU_SRL;
                    F3_OR:   alu_op = ALU_OR;
                    F3_AND:  alu_op = ALU_AND;
                    default: alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_y = op_a + op_b;
        unique case (alu_op)
            ALU_SUB:  alu_y = op_a - op_b;
            ALU_SLL:  alu_y = op_a << shamt;
            ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:  alu_y = op_a ^ op_b;
            ALU_SRL:  alu_y = op_a >> shamt;
            ALU_SRA:  alu_y = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:   alu_y = op_a | op_b;
            ALU_AND:  alu_y = op_a & op_b;
            default:  alu_y = op_a + op_b;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (id_ex_funct3)
            F3_BEQ:  br_cond = op_a == fwd_b;
            F3_BNE:  br_cond = op_a != fwd_b;
            F3_BLT:  br_cond = $signed(op_a) < $signed(fwd_b);
            F3_BGE:  br_cond = $signed(op_a) >= $signed(fwd_b);
            F3_BLTU: br_cond = op_a < fwd_b;
            F3_BGEU: br_cond = op_a >= fwd_b;
            default: br_cond = 1'b0;
        endcase
    end

    // rst_n gating keeps ex_busy low while reset is held.
    assign mul_start = MUL_EN && rst_n && id_ex_valid && !flush
                    && id_ex_ALUOp == ALUOP_R
                    && id_ex_funct7 == FUNCT7_MULDIV && !id_ex_funct3[2];

    mul_iter #(.XLEN(XLEN)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .abort_i   (flush),
        .op_a_i    (op_a),
        .op_b_i    (fwd_b),
        .a_signed_i(id_ex_funct3 != F3_MULHU),
        .b_signed_i(!id_ex_funct3[1]),
        .hi_i      (id_ex_funct3 != F3_MUL),
        .busy_o    (ex_busy),
        .done_o    (mul_done),
        .result_o  (mul_y)
    );

    assign result = mul_done ? mul_y : alu_y;

    always_comb begin
        ctl_d.valid        = id_ex_valid;
        ctl_d.mem_to_reg   = id_ex_MemtoReg;
        ctl_d.mem_read     = id_ex_MemRead;
        ctl_d.mem_write    = id_ex_MemWrite;
        ctl_d.reg_write    = id_ex_RegWrite;
        ctl_d.branch_taken = id_ex_Branch && br_cond && id_ex_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q <= '0;
            tgt_q <= '0;
            res_q <= '0;
            sd_q  <= '0;
            rd_q  <= '0;
        end else if (flush || ex_busy) begin
            ctl_q <= '0;
        end else begin
            ctl_q <= ctl_d;
            tgt_q <= id_ex_pc + id_ex_immediate;
            res_q <= result;
            sd_q  <= fwd_b;
            rd_q  <= id_ex_rd;
        end
    end

    assign ex_mem_valid         = ctl_q.valid;
    assign ex_mem_MemtoReg      = ctl_q.mem_to_reg;
    assign ex_mem_MemRead       = ctl_q.mem_read;
    assign ex_mem_MemWrite      = ctl_q.mem_write;
    assign ex_mem_RegWrite      = ctl_q.reg_write;
    assign ex_mem_branch_taken  = ctl_q.branch_taken;
    assign ex_mem_branch_target = tgt_q;
    assign ex_mem_alu_result    = res_q;
    assign ex_mem_store_data    = sd_q;
    assign ex_mem_rd            = rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed bench for ex_stage against a cycle-level model.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_ex_valid;
    logic [31:0] id_ex_pc, id_ex_rs1val, id_ex_rs2val, id_ex_immediate;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [2:0]  id_ex_funct3;
    logic [6:0]  id_ex_funct7;
    logic        id_ex_ALUSrc, id_ex_MemtoReg, id_ex_MemRead;
    logic        id_ex_MemWrite, id_ex_Branch, id_ex_RegWrite;
    logic [1:0]  id_ex_ALUOp;
    logic        mem_wb_RegWrite;
    logic [4:0]  mem_wb_rd;
    logic [31:0] Write_data;
    logic        flush;
    logic        ex_busy, ex_mem_valid, ex_mem_MemtoReg, ex_mem_MemRead;
    logic        ex_mem_MemWrite, ex_mem_RegWrite, ex_mem_branch_taken;
    logic [31:0] ex_mem_branch_target, ex_mem_alu_result, ex_mem_store_data;
    logic [4:0]  ex_mem_rd;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .id_ex_valid(id_ex_valid),
        .id_ex_pc(id_ex_pc), .id_ex_rs1val(id_ex_rs1val),
        .id_ex_rs2val(id_ex_rs2val), .id_ex_immediate(id_ex_immediate),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_funct3(id_ex_funct3), .id_ex_funct7(id_ex_funct7),
        .id_ex_ALUSrc(id_ex_ALUSrc), .id_ex_MemtoReg(id_ex_MemtoReg),
        .id_ex_MemRead(id_ex_MemRead), .id_ex_MemWrite(id_ex_MemWrite),
        .id_ex_Branch(id_ex_Branch), .id_ex_RegWrite(id_ex_RegWrite),
        .id_ex_ALUOp(id_ex_ALUOp), .mem_wb_RegWrite(mem_wb_RegWrite),
        .mem_wb_rd(mem_wb_rd), .Write_data(Write_data), .flush(flush),
        .ex_busy(ex_busy), .ex_mem_valid(ex_mem_valid),
        .ex_mem_MemtoReg(ex_mem_MemtoReg), .ex_mem_MemRead(ex_mem_MemRead),
        .ex_mem_MemWrite(ex_mem_MemWrite), .ex_mem_RegWrite(ex_mem_RegWrite),
        .ex_mem_branch_taken(ex_mem_branch_taken),
        .ex_mem_branch_target(ex_mem_branch_target),
        .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_store_data(ex_mem_store_data), .ex_mem_rd(ex_mem_rd)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // expected EX/MEM contents and multiply progress
    logic        m_valid, m_mtr, m_mr, m_mw, m_rw, m_bt;
    logic [31:0] m_tgt, m_res, m_sd, m_prod;
    logic [4:0]  m_rd;
    int          m_ph;
    logic        smp_busy;

    task automatic model_reset();
        m_valid = 0; m_mtr = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_bt = 0;
        m_tgt = 0; m_res = 0; m_sd = 0; m_rd = 0; m_prod = 0; m_ph = 0;
    endtask

    function automatic logic [31:0] ref_alu(input logic [1:0] op,
        input logic [2:0] f3, input logic [6:0] f7,
        input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        if (op == 2'd0) return a + b;
        if (op == 2'd1) return a - b;
        case (f3)
            3'd0: return (op == 2'd2 && f7[5]) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return f7[5] ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic bcond(input logic [2:0] f3,
        input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_mul(input logic [2:0] f3,
        input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (f3 != 3'd3) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (f3 <= 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p = ea * eb;
        return (f3 == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] rs,
                                        input logic [31:0] v);
        if (m_rw && !m_mr && m_rd != 0 && m_rd == rs) return m_res;
        if (mem_wb_RegWrite && mem_wb_rd != 0 && mem_wb_rd == rs) return Write_data;
        return v;
    endfunction

    task automatic compare_all();
        chk("valid", 32'(ex_mem_valid), 32'(m_valid));
        chk("memtoreg", 32'(ex_mem_MemtoReg), 32'(m_mtr));
        chk("memread", 32'(ex_mem_MemRead), 32'(m_mr));
        chk("memwrite", 32'(ex_mem_MemWrite), 32'(m_mw));
        chk("regwrite", 32'(ex_mem_RegWrite), 32'(m_rw));
        chk("br_taken", 32'(ex_mem_branch_taken), 32'(m_bt));
        chk("br_target", ex_mem_branch_target, m_tgt);
        chk("result", ex_mem_alu_result, m_res);
        chk("store_data", ex_mem_store_data, m_sd);
        chk("rd", 32'(ex_mem_rd), 32'(m_rd));
    endtask

    // one clock: predict, check busy, clock, check EX/MEM
    task automatic step();
        logic [31:0] fa, fb, ob, res, nprod;
        logic        start, eb, tk;
        int          nph;
        #2;
        fa = fwd(id_ex_rs1, id_ex_rs1val);
        fb = fwd(id_ex_rs2, id_ex_rs2val);
        ob = id_ex_ALUSrc ? id_ex_immediate : fb;
        start = id_ex_valid && !flush && id_ex_ALUOp == 2'd2
             && id_ex_funct7 == 7'h01 && !id_ex_funct3[2];
        eb = (m_ph == 0) ? start : (m_ph <= 32);
        chk("ex_busy", 32'(ex_busy), 32'(eb));
        smp_busy = ex_busy;
        res = (m_ph == 33) ? m_prod
            : ref_alu(id_ex_ALUOp, id_ex_funct3, id_ex_funct7, fa, ob);
        tk = id_ex_Branch && bcond(id_ex_funct3, fa, fb) && id_ex_valid;
        nprod = m_prod;
        if (m_ph == 0) begin
            nph = start ? 1 : 0;
            if (start) nprod = ref_mul(id_ex_funct3, fa, fb);
        end else if (m_ph <= 32) begin
            nph = flush ? 0 : m_ph + 1;
        end else begin
            nph = 0;
        end
        @(posedge clk);
        #1;
        if (flush || eb) begin
            m_valid = 0; m_mtr = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_bt = 0;
        end else begin
            m_valid = id_ex_valid; m_mtr = id_ex_MemtoReg;
            m_mr = id_ex_MemRead; m_mw = id_ex_MemWrite;
            m_rw = id_ex_RegWrite; m_bt = tk;
            m_tgt = id_ex_pc + id_ex_immediate;
            m_res = res; m_sd = fb; m_rd = id_ex_rd;
        end
        m_ph = nph;
        m_prod = nprod;
        compare_all();
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [2:0] f3,
        input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
        input logic [31:0] imm, input logic alusrc, input logic rw);
        id_ex_valid = 1; id_ex_ALUOp = op; id_ex_funct3 = f3;
        id_ex_funct7 = f7; id_ex_rs1 = rs1; id_ex_rs2 = rs2; id_ex_rd = rd;
        id_ex_rs1val = v1; id_ex_rs2val = v2; id_ex_immediate = imm;
        id_ex_ALUSrc = alusrc; id_ex_RegWrite = rw; id_ex_pc = 0;
        id_ex_MemtoReg = 0; id_ex_MemRead = 0; id_ex_MemWrite = 0;
        id_ex_Branch = 0;
    endtask

    task automatic run_mul(input logic [2:0] f3, input logic [31:0] a,
        input logic [31:0] b, input logic [31:0] exp, input string tag);
        int cnt;
        cnt = 0;
        set_instr(2'd2, f3, 7'h01, 5'd10, 5'd11, 5'd12, a, b, 0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            step();
            if (smp_busy) cnt++;
            else break;
        end
        id_ex_valid = 0;
        chk({tag, "_busy_cycles"}, 32'(cnt), 32'd33);
        chk(tag, ex_mem_alu_result, exp);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom % 6)
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom % 40);
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_instr();
        id_ex_valid = ($urandom % 8) != 0;
        id_ex_ALUOp = 2'($urandom);
        id_ex_funct3 = 3'($urandom);
        case ($urandom % 4)
            0: id_ex_funct7 = 7'h00;
            1: id_ex_funct7 = 7'h20;
            2: id_ex_funct7 = 7'h01;
            default: id_ex_funct7 = 7'($urandom);
        endcase
        id_ex_rs1 = 5'($urandom % 4);
        id_ex_rs2 = 5'($urandom % 4);
        id_ex_rd = 5'($urandom % 4);
        id_ex_rs1val = rand_val();
        id_ex_rs2val = rand_val();
        id_ex_immediate = rand_val();
        id_ex_pc = $urandom;
        id_ex_ALUSrc = 1'($urandom);
        id_ex_MemtoReg = 1'($urandom);
        id_ex_MemRead = ($urandom % 4) == 0;
        id_ex_MemWrite = 1'($urandom);
        id_ex_Branch = 1'($urandom);
        id_ex_RegWrite = 1'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; flush = 0;
        mem_wb_RegWrite = 0; mem_wb_rd = 0; Write_data = 0;
        set_instr(2'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        id_ex_valid = 0;
        model_reset();
        #12;
        chk("reset_busy", 32'(ex_busy), 32'd0);
        compare_all();
        rst_n = 1;
        @(posedge clk);
        #1;

        // add x3,x1,x2 then sub x4,x3,x1 forwarding x3
        set_instr(2'd2, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 5, 7, 0, 0, 1);
        step();
        chk("add_x3", ex_mem_alu_result, 32'd12);
        set_instr(2'd2, 3'd0, 7'h20, 5'd3, 5'd1, 5'd4, 0, 5, 0, 0, 1);
        step();
        chk("fwd_sub", ex_mem_alu_result, 32'd7);

        // EX/MEM wins over MEM/WB
        set_instr(2'd3, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 0, 0, 32'h10, 1, 1);
        step();
        mem_wb_RegWrite = 1; mem_wb_rd = 5; Write_data = 32'h20;
        set_instr(2'd2, 3'd0, 7'h00, 5'd5, 5'd0, 5'd6, 32'h99, 0, 0, 0, 1);
        step();
        chk("fwd_prio", ex_mem_alu_result, 32'h10);

        // x0 is never forwarded
        set_instr(2'd3, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 0, 0, 32'h55, 1, 1);
        step();
        mem_wb_rd = 0; Write_data = 32'h77;
        set_instr(2'd2, 3'd0, 7'h00, 5'd0, 5'd0, 5'd7, 32'h33, 0, 0, 0, 1);
        step();
        chk("fwd_x0", ex_mem_alu_result, 32'h33);
        mem_wb_RegWrite = 0;

        run_mul(3'd0, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFEB, "mul");
        run_mul(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");

        // branches
        set_instr(2'd1, 3'd0, 7'h00, 5'd6, 5'd7, 5'd0, 32'hAB, 32'hAB, 32'h10, 0, 0);
        id_ex_Branch = 1; id_ex_pc = 32'h40;
        step();
        chk("beq_taken", 32'(ex_mem_branch_taken), 32'd1);
        chk("beq_target", ex_mem_branch_target, 32'h50);
        set_instr(2'd1, 3'd6, 7'h00, 5'd6, 5'd7, 5'd0, 32'hFFFF_FFFF, 1, 32'h8, 0, 0);
        id_ex_Branch = 1;
        step();
        chk("bltu_not_taken", 32'(ex_mem_branch_taken), 32'd0);

        // flush on the 10th RUN cycle
        set_instr(2'd2, 3'd0, 7'h01, 5'd10, 5'd11, 5'd12, 3, 4, 0, 0, 1);
        step();
        repeat (9) step();
        flush = 1;
        step();
        chk("flush_valid", 32'(ex_mem_valid), 32'd0);
        flush = 0; id_ex_valid = 0;
        #2;
        chk("flush_busy", 32'(ex_busy), 32'd0);
        step();

        // reset pulse mid-RUN
        set_instr(2'd2, 3'd1, 7'h01, 5'd10, 5'd11, 5'd12, 32'hFFFF_FFFB, 9, 0, 0, 1);
        repeat (5) step();
        rst_n = 0;
        #1;
        model_reset();
        chk("rst_busy", 32'(ex_busy), 32'd0);
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1;
        set_instr(2'd2, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 5, 7, 0, 0, 1);
        step();
        chk("post_rst_add", ex_mem_alu_result, 32'd12);

        // random traffic; instruction held while a multiply occupies EX
        for (int i = 0; i < 700; i++) begin
            mem_wb_RegWrite = 1'($urandom);
            mem_wb_rd = 5'($urandom % 4);
            Write_data = rand_val();
            flush = ($urandom % 64) == 0;
            if (!(m_ph >= 1 && m_ph <= 33)) rand_instr();
            step();
        end
        flush = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
